pipe_issue_seq: RTL and testbench

//   Issue-side front end for the 3-stage register/ALU/memory pipeline (rs1,rs2,rd,func,addr -> Z -> regbank[rd], mem[addr]).

---
 rtl/pipe_issue_seq.sv | 142 ++++++++++++++
 tb/tb_pipe_issue_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_seq.sv
// Issue-side front end: buffers packed instruction words in a FIFO and issues at most
// one per cycle to the pipeline operand ports, holding back read-after-write hazards.
module pipe_issue_seq #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HAZ_WIN = 3
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_instr,
  input  logic                     flush,
  output logic                     issue_valid,
  output logic [3:0]               rs1,
  output logic [3:0]               rs2,
  output logic [3:0]               rd,
  output logic [3:0]               func,
  output logic [7:0]               addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  instr_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [HAZ_WIN-1:0]      sb_v;
  logic [HAZ_WIN-1:0][3:0] sb_rd;

  instr_t head_c;
  logic   full_c;
  logic   empty_c;
  logic   hazard_c;
  logic   push_c;
  logic   issue_c;
  logic   stall_c;

  // Head decode and scoreboard comparison against both sources.
  always_comb begin
    head_c   = mem[rd_ptr];
    full_c   = (count == CW'(DEPTH));
    empty_c  = (count == '0);
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < HAZ_WIN; i++) begin
      if (sb_v[i] && ((sb_rd[i] == head_c.rs1) || (sb_rd[i] == head_c.rs2))) begin
        hazard_c = 1'b1;
      end
    end
    push_c  = in_valid && in_ready && !flush;
    issue_c = !empty_c && !hazard_c && !flush;
    stall_c = !empty_c && hazard_c && !flush;
  end

  // Held low during reset so the host never sees a ready it cannot use.
  assign in_ready = rst_n && !full_c;

  // Storage array carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk1) begin
    if (push_c) begin
      mem[wr_ptr] <= instr_t'(in_instr);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (issue_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, issue_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard: one slot per cycle of hazard window, shifted every edge.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v  <= '0;
      sb_rd <= '0;
    end else if (flush) begin
      sb_v  <= '0;
    end else begin
      sb_v[0]  <= issue_c;
      sb_rd[0] <= head_c.rd;
      for (int unsigned i = 1; i < HAZ_WIN; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  end

  // Registered issue port; fields hold their last value between issues.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
    end else begin
      issue_valid <= issue_c;
      if (issue_c) begin
        rs1  <= head_c.rs1;
        rs2  <= head_c.rs2;
        rd   <= head_c.rd;
        func <= head_c.func;
        addr <= head_c.addr;
      end
    end
  end

  // Saturating hazard-stall counter; survives flush.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_issue_seq.sv
// Bench for pipe_issue_seq: directed scenarios plus random traffic, compared every
// cycle against a queue-and-timestamp model of the issue rules.
module tb_pipe_issue_seq;

  localparam int DEPTH   = 8;
  localparam int HAZ_WIN = 3;

  logic        clk1;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic [3:0]  count;
  logic [15:0] stall_cnt;

  pipe_issue_seq #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  int nvec = 0;
  int nerr = 0;

  // Reference state: pending words, edge number of the last issue per register.
  logic [23:0] q[$];
  int          last_iss[16];
  int          cyc;
  logic        e_iv;
  logic [3:0]  e_rs1, e_rs2, e_rd, e_func;
  logic [7:0]  e_addr;
  logic [15:0] e_stall;
  bit          accepted;
  int          iss_edges[$];
  bit          saw_full;

  function automatic logic [23:0] mk(int f, int d, int s1, int s2, int a);
    mk = {4'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int r = 0; r < 16; r++) last_iss[r] = -1000;
  endtask

  task automatic check_all();
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("rs1",         32'(rs1),         32'(e_rs1));
    chk("rs2",         32'(rs2),         32'(e_rs2));
    chk("rd",          32'(rd),          32'(e_rd));
    chk("func",        32'(func),        32'(e_func));
    chk("addr",        32'(addr),        32'(e_addr));
    chk("count",       32'(count),       32'(q.size()));
    chk("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
    chk("stall_cnt",   32'(stall_cnt),   32'(e_stall));
  endtask

  // Apply the current inputs for one clock edge to both model and DUT.
  task automatic step();
    logic [23:0] h;
    bit          rdy;
    bit          haz;
    rdy      = (q.size() < DEPTH);
    accepted = 0;
    e_iv     = 0;
    if (flush) begin
      model_clear();
    end else begin
      if (q.size() > 0) begin
        h   = q[0];
        haz = (cyc - last_iss[h[15:12]] <= HAZ_WIN) || (cyc - last_iss[h[11:8]] <= HAZ_WIN);
        if (haz) begin
          if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
        end else begin
          void'(q.pop_front());
          e_iv   = 1;
          e_func = h[23:20];
          e_rd   = h[19:16];
          e_rs1  = h[15:12];
          e_rs2  = h[11:8];
          e_addr = h[7:0];
          last_iss[h[19:16]] = cyc;
        end
      end
      if (in_valid && rdy) begin
        q.push_back(in_instr);
        accepted = 1;
      end
    end
    @(posedge clk1);
    #1;
    cyc++;
    check_all();
    if (issue_valid) iss_edges.push_back(cyc);
    if (count == 4'(DEPTH)) saw_full = 1;
  endtask

  task automatic idle(int n);
    in_valid = 0;
    flush    = 0;
    repeat (n) step();
  endtask

  // Host offers a word and holds it until taken; bounded wait.
  task automatic offer(logic [23:0] w);
    int tries;
    in_valid = 1;
    in_instr = w;
    flush    = 0;
    tries    = 0;
    do begin
      step();
      tries++;
    end while (!accepted && tries < 60);
    if (!accepted) chk("offer_timeout", 32'(0), 32'(1));
    in_valid = 0;
  endtask

  task automatic do_reset();
    in_valid = 0;
    flush    = 0;
    rst_n    = 0;
    #2;
    model_clear();
    e_iv = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_func = 0; e_addr = 0; e_stall = 0;
    chk("rst_issue_valid", 32'(issue_valid), 32'(0));
    chk("rst_count",       32'(count),       32'(0));
    chk("rst_in_ready",    32'(in_ready),    32'(0));
    chk("rst_stall",       32'(stall_cnt),   32'(0));
    chk("rst_fields",      32'({rs1, rs2, rd, func, addr}), 32'(0));
    @(posedge clk1);
    #3;
    rst_n = 1;
    cyc++;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [23:0] pend;
    bit          have;
    int          acc_edge;
    int          s0;
    clk1     = 0;
    rst_n    = 0;
    in_valid = 0;
    in_instr = '0;
    flush    = 0;
    cyc      = 0;
    saw_full = 0;
    do_reset();

    // Directed stream, one offer per cycle; the 4th word reads r12 written by the 2nd.
    iss_edges.delete();
    offer(mk(0, 10, 3, 5, 125));
    offer(mk(2, 12, 3, 8, 126));
    offer(mk(11, 13, 7, 3, 128));
    offer(mk(0, 0, 12, 13, 130));
    idle(8);
    chk("stream_pulses", 32'(iss_edges.size()), 32'(4));

    // RAW hazard: dependent word waits exactly HAZ_WIN bubbles.
    iss_edges.delete();
    s0 = int'(stall_cnt);
    offer(mk(0, 10, 3, 5, 125));
    offer(mk(1, 14, 10, 5, 127));
    idle(8);
    chk("haz_pulses", 32'(iss_edges.size()), 32'(2));
    if (iss_edges.size() == 2) chk("haz_gap", 32'(iss_edges[1] - iss_edges[0]), 32'(HAZ_WIN + 1));
    chk("haz_stall", 32'(int'(stall_cnt) - s0), 32'(HAZ_WIN));

    // Dependent chain fills the FIFO; extra words are held until a pop frees space.
    saw_full = 0;
    for (int k = 0; k < 12; k++) offer(mk(k, 1, 1, 1, 40 + k));
    chk("saw_full", 32'(saw_full), 32'(1));
    idle(60);
    chk("chain_drained", 32'(count), 32'(0));

    // Flush with occupancy 5 and a concurrent push; dependency on flushed history vanishes.
    for (int k = 0; k < 7; k++) offer(mk(k, 2, 2, 2, 60 + k));
    chk("pre_flush_count", 32'(count), 32'(5));
    flush    = 1;
    in_valid = 1;
    in_instr = mk(9, 9, 9, 9, 99);
    step();
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_iv",    32'(issue_valid), 32'(0));
    flush = 0;
    iss_edges.delete();
    offer(mk(3, 4, 2, 2, 200));
    acc_edge = cyc;
    step();
    chk("post_flush_issue", 32'(iss_edges.size()), 32'(1));
    if (iss_edges.size() == 1) chk("post_flush_latency", 32'(iss_edges[0]), 32'(acc_edge + 1));
    idle(4);

    // Random traffic on a small register space so hazards, wrap and full are frequent.
    have = 0;
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
      end
      if (!have) begin
        pend = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom)};
        have = 1;
      end
      in_instr = pend;
      in_valid = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 49) == 0);
      step();
      if (accepted) have = 0;
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
